decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter PC_W, default 32, width of the program-counter field carried with each instruction.
REQ-002 Parameter DEPTH, default 2, output queue entries; legal range 1..8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discard all queued entries.
REQ-006 in_valid  input  1  instruction/pc present.
REQ-007 in_ready  output  1  stage can accept an instruction this cycle.
REQ-008 instruction  input  32  RV32 instruction word.
REQ-009 pc  input  PC_W  address of the instruction.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  consumer takes head entry.
REQ-012 Output fields, all from the head entry: alu_op[3:0], reg_write, mem_read, mem_write, branch, jump, illegal, rd[4:0], rs1[4:0], rs2[4:0], funct3[2:0], imm[31:0], out_pc[PC_W-1:0].
REQ-013 count  output  4  number of occupied entries.

Function
REQ-014 Decode is combinational on instruction; the decoded record is written to the queue tail on a cycle where in_valid && in_ready.
REQ-015 Latency: an instruction accepted at edge N is visible at the queue head (out_valid=1) after edge N when the queue was empty; the stage has no combinational in-to-out path.
REQ-016 in_ready = (count < DEPTH); it does not depend on out_ready.
REQ-017 Pop occurs on out_valid && out_ready; push and pop in the same cycle leave count unchanged and preserve order.
REQ-018 Opcode map: 0110011 R: reg_write, alu_op from funct3/funct7; 0010011 I-ALU: reg_write, imm I-type; 0000011 LOAD: mem_read, reg_write, alu_op ADD; 0100011 STORE: mem_write, alu_op ADD, imm S-type; 1100011 BRANCH: branch, alu_op SUB, imm B-type; 0110111 LUI: reg_write, alu_op PASS; 0010111 AUIPC: reg_write, alu_op ADD; 1101111 JAL and 1100111 JALR: jump, reg_write.
REQ-019 alu_op encoding: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASS(imm); 1100-1111 reserved for REQ-029.
REQ-020 imm is sign-extended to 32 bits per I/S/B/U/J format; U-type is instr[31:12]<<12; bit 0 of B/J immediates is 0.
REQ-021 Unknown opcode, or funct7 not in {0000000, 0100000} for R-type: illegal=1, reg_write/mem_read/mem_write/branch/jump=0, alu_op=0000, imm=0; the entry is still queued.
REQ-022 SUB/SRA selected only when funct7=0100000; funct7=0100000 with funct3 other than 000/101 is illegal.
REQ-023 flush: count becomes 0 and out_valid 0 on the next edge; a simultaneous push is discarded; flush has priority over push and pop.
REQ-024 When out_valid=0 all decoded outputs read 0.

Reset
REQ-025 rst at an edge sets count=0, read/write pointers=0, out_valid=0, in_ready=1; takes priority over flush, push and pop.
REQ-026 Reset asserted mid-stream drops all queued entries; no entry reappears after reset release.
REQ-027 Queue storage is not reset; only pointers and count are.

Configuration
REQ-028 Macro DECODE_STAGE_RV32M_EN controls M-extension decode.
REQ-029 With DECODE_STAGE_RV32M_EN defined: opcode 0110011 with funct7=0000001 decodes as reg_write=1, alu_op 1100 MUL (funct3 000), 1101 MULH* (001-011), 1110 DIV/DIVU (100-101), 1111 REM/REMU (110-111).
REQ-030 Without DECODE_STAGE_RV32M_EN: funct7=0000001 is illegal per REQ-021.

Verification
REQ-031 Push 0x002081B3 (ADD x3,x1,x2) into empty queue -> next cycle out_valid=1, alu_op=0000, reg_write=1, rd=3, rs1=1, rs2=2, illegal=0.
REQ-032 Push 0x0040A183 (LW), 0x0030A223 (SW), 0x00208063 (BEQ) back-to-back, DEPTH=4, out_ready=1 -> outputs in order: mem_read/imm=4, mem_write/imm=4, branch/alu_op=0001/imm=0.
REQ-033 DEPTH=2, out_ready=0, push 3 instructions -> count=2, in_ready=0, third held; raise out_ready -> third accepted, order preserved.
REQ-034 Push 0x0000007F -> illegal=1, all controls 0; push 0x022081B3 -> illegal=1 without macro, alu_op=1100 with macro.
REQ-035 Queue full, assert flush and in_valid together -> next cycle count=0, out_valid=0; rst mid-stream -> count=0, in_ready=1.
REQ-036 Push 0x001001EF (JAL x3) -> jump=1, reg_write=1, imm=0x00000800; push 0x000011B7 (LUI) -> alu_op=1010, imm=0x00001000.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32 instruction decode stage with an output queue
//
// Decodes one RV32 instruction per cycle and queues the decoded record
// (controls, register fields, immediate, pc) in a DEPTH-entry FIFO.
//
// Parameters: PC_W  - width of the pc carried with each instruction
//             DEPTH - output queue entries (1..8)
// Ports:      clk, rst (sync, active-high), flush (drop all entries)
//             in_valid/in_ready, instruction[31:0], pc[PC_W-1:0]  - input side
//             out_valid/out_ready plus decoded fields of the head entry
//             count[3:0] - occupied entries
// Build option: define DECODE_STAGE_RV32M_EN to decode the M extension.
module decode_stage #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [PC_W-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_op,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic            jump,
    output logic            illegal,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [31:0]     imm,
    output logic [PC_W-1:0] out_pc,
    output logic [3:0]      count
);

    localparam logic [3:0] ALU_ADD  = 4'b0000, ALU_SUB = 4'b0001, ALU_SLL = 4'b0010,
                           ALU_SLT  = 4'b0011, ALU_SLTU = 4'b0100, ALU_XOR = 4'b0101,
                           ALU_SRL  = 4'b0110, ALU_SRA = 4'b0111, ALU_OR  = 4'b1000,
                           ALU_AND  = 4'b1001, ALU_PASS = 4'b1010;

    // Pointer width rounds storage up to a power of two so pointer and
    // array index widths always agree; slots beyond DEPTH are never written.
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 1 << PW;

    typedef struct packed {
        logic [3:0]      alu_op;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            illegal;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [31:0]     imm;
        logic [PC_W-1:0] pc;
    } rec_t;

    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [3:0]  alu_f3;
    rec_t        dec, head;

    assign opcode = instruction[6:0];
    assign f3     = instruction[14:12];
    assign f7     = instruction[31:25];
    assign imm_i  = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b  = {{19{instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u  = {instruction[31:12], 12'b0};
    assign imm_j  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                     instruction[20], instruction[30:21], 1'b0};

    // Base ALU operation selected by funct3 for R-type and I-ALU forms.
    always_comb begin
        alu_f3 = ALU_ADD;
        case (f3)
            3'b000: alu_f3 = ALU_ADD;
            3'b001: alu_f3 = ALU_SLL;
            3'b010: alu_f3 = ALU_SLT;
            3'b011: alu_f3 = ALU_SLTU;
            3'b100: alu_f3 = ALU_XOR;
            3'b101: alu_f3 = ALU_SRL;
            3'b110: alu_f3 = ALU_OR;
            default: alu_f3 = ALU_AND;
        endcase
    end

    always_comb begin
        dec        = '0;
        dec.rd     = instruction[11:7];
        dec.rs1    = instruction[19:15];
        dec.rs2    = instruction[24:20];
        dec.funct3 = f3;
        dec.pc     = pc;
        case (opcode)
            7'b0110011: begin
                if (f7 == 7'b0000000) begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = alu_f3;
                end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
`ifdef DECODE_STAGE_RV32M_EN
                end else if (f7 == 7'b0000001) begin
                    dec.reg_write = 1'b1;
                    case (f3)
                        3'b000:                 dec.alu_op = 4'b1100;
                        3'b001, 3'b010, 3'b011: dec.alu_op = 4'b1101;
                        3'b100, 3'b101:         dec.alu_op = 4'b1110;
                        default:                dec.alu_op = 4'b1111;
                    endcase
`endif
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            7'b0010011: begin
                dec.reg_write = 1'b1;
                dec.imm       = imm_i;
                // SRAI is the only I-ALU form that uses the upper immediate bits
                dec.alu_op    = (f3 == 3'b101 && f7 == 7'b0100000) ? ALU_SRA : alu_f3;
            end
            7'b0000011: begin
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm       = imm_i;
            end
            7'b0100011: begin
                dec.mem_write = 1'b1;
                dec.imm       = imm_s;
            end
            7'b1100011: begin
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
                dec.imm    = imm_b;
            end
            7'b0110111: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = ALU_PASS;
                dec.imm       = imm_u;
            end
            7'b0010111: begin
                dec.reg_write = 1'b1;
                dec.imm       = imm_u;
            end
            7'b1101111: begin
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm       = imm_j;
            end
            7'b1100111: begin
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm       = imm_i;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    rec_t          mem [SLOTS];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [3:0]    cnt;
    logic          push, pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign in_ready  = (cnt < 4'(DEPTH));
    assign out_valid = (cnt != 4'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= 4'd0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + 4'd1;
                2'b01:   cnt <= cnt - 4'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) mem[wr_ptr] <= dec;
    end

    assign head      = out_valid ? mem[rd_ptr] : '0;
    assign alu_op    = head.alu_op;
    assign reg_write = head.reg_write;
    assign mem_read  = head.mem_read;
    assign mem_write = head.mem_write;
    assign branch    = head.branch;
    assign jump      = head.jump;
    assign illegal   = head.illegal;
    assign rd        = head.rd;
    assign rs1       = head.rs1;
    assign rs2       = head.rs2;
    assign funct3    = head.funct3;
    assign imm       = head.imm;
    assign out_pc    = head.pc;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage at DEPTH 2 and 4
module tb_decode_stage;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic [31:0] pc;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic [31:0] pc = 32'h0;
    logic [31:0] next_pc = 32'h1000;
    rec_t        cur_exp = '0;
    bit          mon_en = 1'b0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int D = (k == 0) ? 2 : 4;
        logic        in_ready, out_valid, reg_write, mem_read, mem_write, branch, jump, illegal;
        logic [3:0]  alu_op, count;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  funct3;
        logic [31:0] imm, out_pc;
        rec_t        obs;
        rec_t        q[$];

        assign obs = {alu_op, reg_write, mem_read, mem_write, branch, jump, illegal,
                      rd, rs1, rs2, funct3, imm, out_pc};

        decode_stage #(.PC_W(32), .DEPTH(D)) u_dut (
            .clk(clk), .rst(rst), .flush(flush),
            .in_valid(in_valid), .in_ready(in_ready),
            .instruction(instruction), .pc(pc),
            .out_valid(out_valid), .out_ready(out_ready),
            .alu_op(alu_op), .reg_write(reg_write), .mem_read(mem_read),
            .mem_write(mem_write), .branch(branch), .jump(jump), .illegal(illegal),
            .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .imm(imm),
            .out_pc(out_pc), .count(count)
        );

        always @(negedge clk) begin
            if (mon_en) begin
                chk($sformatf("d%0d_count", D), 128'(count), 128'(q.size()));
                chk($sformatf("d%0d_in_ready", D), 128'(in_ready), 128'(q.size() < D));
                chk($sformatf("d%0d_out_valid", D), 128'(out_valid), 128'(q.size() != 0));
                if (out_valid && q.size() != 0) begin
                    chk($sformatf("d%0d_head", D), 128'(obs), 128'(q[0]));
                    if (out_ready) void'(q.pop_front());
                end else if (!out_valid) begin
                    chk($sformatf("d%0d_idle_zero", D), 128'(obs), 128'(0));
                end
                if (rst || flush) q.delete();
                else if (in_valid && in_ready) q.push_back(cur_exp);
            end
        end
    end

    // ctl = {reg_write, mem_read, mem_write, branch, jump, illegal}
    task automatic drive(input logic [31:0] ins, input logic [3:0] alu,
                         input logic [5:0] ctl, input logic [31:0] ie);
        instruction = ins;
        pc          = next_pc;
        cur_exp     = {alu, ctl, ins[11:7], ins[19:15], ins[24:20], ins[14:12], ie, next_pc};
        next_pc     = next_pc + 32'd4;
        in_valid    = 1'b1;
    endtask

    task automatic wait_accept(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = g_dut[0].in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk(tag, 128'(got), 128'(1));
    endtask

    task automatic send(input logic [31:0] ins, input logic [3:0] alu,
                        input logic [5:0] ctl, input logic [31:0] ie);
        drive(ins, alu, ctl, ie);
        wait_accept($sformatf("accept_%h", ins));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        idle(2);
        mon_en = 1'b1;
        chk("rst_count", 128'(g_dut[0].count), 128'(0));
        chk("rst_in_ready", 128'(g_dut[0].in_ready), 128'(1));
        chk("rst_out_valid", 128'(g_dut[0].out_valid), 128'(0));
        rst = 1'b0;
        out_ready = 1'b1;
        idle(1);

        send(32'h002081B3, 4'b0000, 6'b100000, 32'h0);
        chk("add_out_valid", 128'(g_dut[0].out_valid), 128'(1));
        chk("add_alu_op", 128'(g_dut[0].alu_op), 128'(4'b0000));
        chk("add_reg_write", 128'(g_dut[0].reg_write), 128'(1));
        chk("add_rd", 128'(g_dut[0].rd), 128'(3));
        chk("add_rs1", 128'(g_dut[0].rs1), 128'(1));
        chk("add_rs2", 128'(g_dut[0].rs2), 128'(2));
        chk("add_illegal", 128'(g_dut[0].illegal), 128'(0));
        idle(1);

        send(32'h0040A183, 4'b0000, 6'b110000, 32'h4);
        send(32'h0030A223, 4'b0000, 6'b001000, 32'h4);
        send(32'h00208063, 4'b0001, 6'b000100, 32'h0);
        send(32'hFE209EE3, 4'b0001, 6'b000100, 32'hFFFFFFFC);
        send(32'h402081B3, 4'b0001, 6'b100000, 32'h0);
        send(32'h4020D1B3, 4'b0111, 6'b100000, 32'h0);
        send(32'h402091B3, 4'b0000, 6'b000001, 32'h0);
        send(32'hFFF08193, 4'b0000, 6'b100000, 32'hFFFFFFFF);
        send(32'h00001197, 4'b0000, 6'b100000, 32'h00001000);
        send(32'h0000007F, 4'b0000, 6'b000001, 32'h0);
        chk("ill_illegal", 128'(g_dut[0].illegal), 128'(1));
        chk("ill_controls", 128'({g_dut[0].reg_write, g_dut[0].mem_read, g_dut[0].mem_write,
                                  g_dut[0].branch, g_dut[0].jump, g_dut[0].alu_op}), 128'(0));
`ifdef DECODE_STAGE_RV32M_EN
        send(32'h022081B3, 4'b1100, 6'b100000, 32'h0);
        chk("mul_alu_op", 128'(g_dut[0].alu_op), 128'(4'b1100));
`else
        send(32'h022081B3, 4'b0000, 6'b000001, 32'h0);
        chk("mul_illegal", 128'(g_dut[0].illegal), 128'(1));
`endif
        send(32'h001001EF, 4'b0000, 6'b100010, 32'h00000800);
        chk("jal_imm", 128'(g_dut[0].imm), 128'(32'h00000800));
        send(32'h000011B7, 4'b1010, 6'b100000, 32'h00001000);
        chk("lui_imm", 128'(g_dut[0].imm), 128'(32'h00001000));
        idle(4);

        // Backpressure: DEPTH=2 instance fills and holds the third instruction.
        out_ready = 1'b0;
        send(32'h00308093, 4'b0000, 6'b100000, 32'h3);
        send(32'h0010C133, 4'b0101, 6'b100000, 32'h0);
        drive(32'h0020F1B3, 4'b1001, 6'b100000, 32'h0);
        idle(3);
        chk("full_count", 128'(g_dut[0].count), 128'(2));
        chk("full_in_ready", 128'(g_dut[0].in_ready), 128'(0));
        out_ready = 1'b1;
        wait_accept("accept_held");
        idle(8);

        // Flush with a simultaneous push while full.
        out_ready = 1'b0;
        send(32'h00500293, 4'b0000, 6'b100000, 32'h5);
        send(32'h00600313, 4'b0000, 6'b100000, 32'h6);
        drive(32'h00700393, 4'b0000, 6'b100000, 32'h7);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 128'(g_dut[0].count), 128'(0));
        chk("flush_out_valid", 128'(g_dut[0].out_valid), 128'(0));
        chk("flush_count_d4", 128'(g_dut[1].count), 128'(0));
        idle(2);

        // Flush with a push while not full: the push is dropped too.
        send(32'h00800413, 4'b0000, 6'b100000, 32'h8);
        drive(32'h00900493, 4'b0000, 6'b100000, 32'h9);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_push_count", 128'(g_dut[0].count), 128'(0));
        idle(2);

        // Reset mid-stream.
        send(32'h00A00513, 4'b0000, 6'b100000, 32'hA);
        send(32'h00B00593, 4'b0000, 6'b100000, 32'hB);
        rst = 1'b1;
        idle(1);
        chk("mid_rst_count", 128'(g_dut[0].count), 128'(0));
        chk("mid_rst_in_ready", 128'(g_dut[0].in_ready), 128'(1));
        rst = 1'b0;
        out_ready = 1'b1;
        idle(4);
        chk("post_rst_out_valid", 128'(g_dut[1].out_valid), 128'(0));

        send(32'h00C00613, 4'b0000, 6'b100000, 32'hC);
        send(32'h0000A683, 4'b0000, 6'b110000, 32'h0);
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
